// File: rtl/synth_voice_controller_pkg.sv
// ---------------------------------------------------------------------------
// synth_voice_controller_pkg
// Shared types and constants for the polyphonic voice engine:
//   env_state_t      - per-voice ADSR envelope state
//   DEF_*            - default envelope step sizes and sustain level
//   SAMPLE_W         - width of the signed mixed output sample
//   PHASE_W/LEVEL_W  - DDS phase accumulator and envelope level widths
// ---------------------------------------------------------------------------
package synth_voice_controller_pkg;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam int SAMPLE_W = 24;
    localparam int PHASE_W  = 32;
    localparam int LEVEL_W  = 16;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX             = 16'hFFFF;
    localparam logic [LEVEL_W-1:0] DEF_ATTACK_STEP       = 16'd64;
    localparam logic [LEVEL_W-1:0] DEF_DECAY_STEP        = 16'd16;
    localparam logic [LEVEL_W-1:0] DEF_SUSTAIN_LEVEL     = 16'hC000;
    localparam logic [LEVEL_W-1:0] DEF_RELEASE_STEP      = 16'd8;

endpackage

// File: rtl/synth_voice_controller_adsr_step.sv
// ---------------------------------------------------------------------------
// synth_voice_controller_adsr_step
// Combinational one-frame advance of a single voice's ADSR envelope.
// Instantiated once and shared by all voices through the slot multiplexer.
// Ports:
//   state      in  current envelope state of the slot's voice
//   level      in  current envelope level (unsigned 16-bit gain)
//   next_state out state after this frame's step
//   next_level out level after this frame's step
// ---------------------------------------------------------------------------
module synth_voice_controller_adsr_step
    import synth_voice_controller_pkg::*;
#(
    parameter logic [LEVEL_W-1:0] ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter logic [LEVEL_W-1:0] DECAY_STEP    = DEF_DECAY_STEP,
    parameter logic [LEVEL_W-1:0] SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
    parameter logic [LEVEL_W-1:0] RELEASE_STEP  = DEF_RELEASE_STEP
) (
    input  env_state_t         state,
    input  logic [LEVEL_W-1:0] level,
    output env_state_t         next_state,
    output logic [LEVEL_W-1:0] next_level
);

    // Add/subtract one bit wider so the carry/borrow tells us we crossed a limit.
    function automatic logic [LEVEL_W:0] add_wide(input logic [LEVEL_W-1:0] a,
                                                  input logic [LEVEL_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [LEVEL_W:0] sub_wide(input logic [LEVEL_W-1:0] a,
                                                  input logic [LEVEL_W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    logic [LEVEL_W:0] att_sum;
    logic [LEVEL_W:0] dec_diff;
    logic [LEVEL_W:0] rel_diff;

    always_comb begin
        att_sum    = add_wide(level, ATTACK_STEP);
        dec_diff   = sub_wide(level, DECAY_STEP);
        rel_diff   = sub_wide(level, RELEASE_STEP);
        next_state = state;
        next_level = level;
        unique case (state)
            ENV_IDLE: begin
                next_level = '0;
            end
            ENV_ATTACK: begin
                if (att_sum >= {1'b0, LEVEL_MAX}) begin
                    next_level = LEVEL_MAX;
                    next_state = ENV_DECAY;
                end else begin
                    next_level = att_sum[LEVEL_W-1:0];
                end
            end
            ENV_DECAY: begin
                if (dec_diff[LEVEL_W] || (dec_diff[LEVEL_W-1:0] <= SUSTAIN_LEVEL)) begin
                    next_level = SUSTAIN_LEVEL;
                    next_state = ENV_SUSTAIN;
                end else begin
                    next_level = dec_diff[LEVEL_W-1:0];
                end
            end
            ENV_SUSTAIN: begin
                next_level = level;
            end
            ENV_RELEASE: begin
                if (rel_diff[LEVEL_W] || (rel_diff[LEVEL_W-1:0] == '0)) begin
                    next_level = '0;
                    next_state = ENV_IDLE;
                end else begin
                    next_level = rel_diff[LEVEL_W-1:0];
                end
            end
            default: begin
                next_level = '0;
                next_state = ENV_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/synth_voice_controller.sv
// ---------------------------------------------------------------------------
// synth_voice_controller
// Polyphonic DDS sawtooth voice engine. One voice is processed per clock;
// a frame is NUM_VOICES clocks and produces one signed mixed sample.
// Ports:
//   i_clk              system clock, rising edge
//   i_reset            synchronous active-high reset, clears all voice state
//   i_SPI_note_status  1 = note-on, 0 = note-off (qualified by flag_adsr)
//   i_SPI_voice_index  target voice of the SPI command
//   i_SPI_tuning_code  DDS phase increment (qualified by flag_dds)
//   i_SPI_velocity     reserved, unused
//   i_SPI_flag_dds     strobe: write tuning_code to the target voice
//   i_SPI_flag_adsr    strobe: apply note_status to the target voice
//   o_mixed_sample     signed sum of all voice contributions, once per frame
// ---------------------------------------------------------------------------
module synth_voice_controller
    import synth_voice_controller_pkg::*;
#(
    parameter int                 NUM_VOICES    = 256,
    parameter logic [LEVEL_W-1:0] ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter logic [LEVEL_W-1:0] DECAY_STEP    = DEF_DECAY_STEP,
    parameter logic [LEVEL_W-1:0] SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
    parameter logic [LEVEL_W-1:0] RELEASE_STEP  = DEF_RELEASE_STEP
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_SPI_note_status,
    input  logic [7:0]                 i_SPI_voice_index,
    input  logic [PHASE_W-1:0]         i_SPI_tuning_code,
    input  logic [6:0]                 i_SPI_velocity,
    input  logic                       i_SPI_flag_dds,
    input  logic                       i_SPI_flag_adsr,
    output logic signed [SAMPLE_W-1:0] o_mixed_sample
);

    localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [PHASE_W-1:0] tuning    [NUM_VOICES];
    logic [PHASE_W-1:0] phase     [NUM_VOICES];
    logic [LEVEL_W-1:0] env_level [NUM_VOICES];
    env_state_t         env_state [NUM_VOICES];

    logic [VOICE_W-1:0]         voice_cnt;
    logic signed [SAMPLE_W-1:0] acc;

    logic [PHASE_W-1:0]         phase_cur;
    logic [PHASE_W-1:0]         tuning_cur;
    logic [LEVEL_W-1:0]         level_cur;
    env_state_t                 state_cur;
    env_state_t                 slot_next_state;
    logic [LEVEL_W-1:0]         slot_next_level;
    logic signed [15:0]         saw;
    logic signed [32:0]         saw_ext;
    logic signed [32:0]         gain_ext;
    logic signed [32:0]         prod;
    logic signed [15:0]         contrib;
    logic signed [SAMPLE_W-1:0] frame_sum;
    logic                       first_slot;
    logic                       last_slot;

    logic                       spi_idx_ok;
    logic [VOICE_W-1:0]         spi_idx;
    env_state_t                 spi_state;

    logic                       unused_bits;

    // Slot operands for the voice currently owning the datapath
    assign phase_cur  = phase[voice_cnt];
    assign tuning_cur = tuning[voice_cnt];
    assign level_cur  = env_level[voice_cnt];
    assign state_cur  = env_state[voice_cnt];
    assign first_slot = (voice_cnt == '0);
    assign last_slot  = (voice_cnt == VOICE_W'(NUM_VOICES - 1));

    // Inverting the phase MSB turns the unsigned phase into a signed ramp
    assign saw      = {~phase_cur[PHASE_W-1], phase_cur[PHASE_W-2:16]};
    assign saw_ext  = 33'(saw);
    assign gain_ext = 33'($signed({1'b0, level_cur}));
    assign prod     = saw_ext * gain_ext;
    assign contrib  = prod[31:16];

    assign frame_sum = first_slot ? SAMPLE_W'(contrib) : (acc + SAMPLE_W'(contrib));

    synth_voice_controller_adsr_step #(
        .ATTACK_STEP   (ATTACK_STEP),
        .DECAY_STEP    (DECAY_STEP),
        .SUSTAIN_LEVEL (SUSTAIN_LEVEL),
        .RELEASE_STEP  (RELEASE_STEP)
    ) u_adsr_step (
        .state      (state_cur),
        .level      (level_cur),
        .next_state (slot_next_state),
        .next_level (slot_next_level)
    );

    // SPI command decode; note-off on an idle voice leaves it idle
    assign spi_idx_ok = ({24'd0, i_SPI_voice_index} < 32'(NUM_VOICES));
    assign spi_idx    = VOICE_W'(i_SPI_voice_index);

    always_comb begin
        spi_state = ENV_RELEASE;
        if (i_SPI_note_status) begin
            spi_state = ENV_ATTACK;
        end else if (env_state[spi_idx] == ENV_IDLE) begin
            spi_state = ENV_IDLE;
        end
    end

    assign unused_bits = ^{i_SPI_velocity, prod[32], prod[15:0]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                tuning[i]    <= '0;
                phase[i]     <= '0;
                env_level[i] <= '0;
                env_state[i] <= ENV_IDLE;
            end
            voice_cnt      <= '0;
            acc            <= '0;
            o_mixed_sample <= '0;
        end else begin
            // Slot commit; the counter wraps naturally since NUM_VOICES is 2^n
            voice_cnt            <= voice_cnt + VOICE_W'(1);
            phase[voice_cnt]     <= phase_cur + tuning_cur;
            env_level[voice_cnt] <= slot_next_level;
            env_state[voice_cnt] <= slot_next_state;
            acc                  <= frame_sum;
            if (last_slot) begin
                o_mixed_sample <= frame_sum;
            end

            // SPI writes come last so they win a collision with the slot
            if (spi_idx_ok && i_SPI_flag_dds) begin
                tuning[spi_idx] <= i_SPI_tuning_code;
            end
            if (spi_idx_ok && i_SPI_flag_adsr) begin
                env_state[spi_idx] <= spi_state;
            end
        end
    end

endmodule

// File: tb/tb_synth_voice_controller.sv
module tb_synth_voice_controller;
    import synth_voice_controller_pkg::*;

    localparam int          NV    = 8;
    localparam logic [15:0] ATT   = 16'h1000;
    localparam logic [15:0] DEC   = 16'h0800;
    localparam logic [15:0] SUS   = 16'hC000;
    localparam logic [15:0] REL   = 16'h0400;
    localparam int unsigned TUNE1 = 32'h0A00_0000;
    localparam int unsigned TUNE2 = 32'h0C80_0000;

    localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               note_status = 1'b0;
    logic [7:0]         voice_index = 8'd0;
    logic [31:0]        tuning_code = 32'd0;
    logic [6:0]         velocity = 7'd0;
    logic               flag_dds = 1'b0;
    logic               flag_adsr = 1'b0;
    logic signed [23:0] mixed;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int unsigned m_tun [NV];
    int unsigned m_ph  [NV];
    int          m_lv  [NV];
    int          m_st  [NV];
    int          m_contrib [NV];
    int          m_slot, m_acc, m_out;

    always #5 clk = ~clk;

    synth_voice_controller #(
        .NUM_VOICES    (NV),
        .ATTACK_STEP   (ATT),
        .DECAY_STEP    (DEC),
        .SUSTAIN_LEVEL (SUS),
        .RELEASE_STEP  (REL)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_SPI_note_status (note_status),
        .i_SPI_voice_index (voice_index),
        .i_SPI_tuning_code (tuning_code),
        .i_SPI_velocity    (velocity),
        .i_SPI_flag_dds    (flag_dds),
        .i_SPI_flag_adsr   (flag_adsr),
        .o_mixed_sample    (mixed)
    );

    function automatic env_state_t to_env(input int s);
        case (s)
            M_ATT:   return ENV_ATTACK;
            M_DEC:   return ENV_DECAY;
            M_SUS:   return ENV_SUSTAIN;
            M_REL:   return ENV_RELEASE;
            default: return ENV_IDLE;
        endcase
    endfunction

    // One clock of the engine: voice m_slot is mixed and advanced, then SPI overrides
    task automatic model_edge(input bit r, input bit fd, input bit fa, input bit ns,
                              input int idx, input int unsigned code);
        int     v, saw, spi_st;
        longint p;
        if (r) begin
            for (int i = 0; i < NV; i++) begin
                m_tun[i] = 0; m_ph[i] = 0; m_lv[i] = 0; m_st[i] = M_IDLE; m_contrib[i] = 0;
            end
            m_slot = 0; m_acc = 0; m_out = 0;
            return;
        end
        spi_st = M_REL;
        if (idx < NV) spi_st = ns ? M_ATT : ((m_st[idx] == M_IDLE) ? M_IDLE : M_REL);
        v   = m_slot;
        saw = int'(m_ph[v] >> 16) - 32768;
        p   = longint'(saw) * longint'(m_lv[v]);
        m_contrib[v] = int'(p >>> 16);
        m_acc = (v == 0) ? m_contrib[v] : m_acc + m_contrib[v];
        if (v == NV - 1) m_out = m_acc;
        m_ph[v] = m_ph[v] + m_tun[v];
        case (m_st[v])
            M_ATT: begin
                m_lv[v] = m_lv[v] + int'(ATT);
                if (m_lv[v] >= 65535) begin m_lv[v] = 65535; m_st[v] = M_DEC; end
            end
            M_DEC: begin
                m_lv[v] = m_lv[v] - int'(DEC);
                if (m_lv[v] <= int'(SUS)) begin m_lv[v] = int'(SUS); m_st[v] = M_SUS; end
            end
            M_REL: begin
                m_lv[v] = m_lv[v] - int'(REL);
                if (m_lv[v] <= 0) begin m_lv[v] = 0; m_st[v] = M_IDLE; end
            end
            M_IDLE:  m_lv[v] = 0;
            default: ;
        endcase
        m_slot = (m_slot + 1) % NV;
        if (idx < NV) begin
            if (fd) m_tun[idx] = code;
            if (fa) m_st[idx] = spi_st;
        end
    endtask

    task automatic step(input bit r, input bit fd, input bit fa, input bit ns,
                        input int idx, input int unsigned code);
        rst = r; flag_dds = fd; flag_adsr = fa; note_status = ns;
        voice_index = 8'(idx); tuning_code = code; velocity = 7'($urandom);
        @(posedge clk);
        model_edge(r, fd, fa, ns, idx, code);
        #1;
        rst = 1'b0; flag_dds = 1'b0; flag_adsr = 1'b0;
    endtask

    task automatic step_idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic run_frame();
        do step_idle(); while (m_slot != 0);
    endtask

    task automatic goto_slot(input int s);
        while (m_slot != s) step_idle();
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (mixed !== 24'sd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", mixed); end
        checks++;
        if (dut.voice_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dut.voice_cnt); end
        for (int f = 0; f < 10; f++) begin
            run_frame();
            checks++;
            if (int'(mixed) !== 0) begin errors++; $display("FAIL idle_out f%0d: got %0d expected 0", f, mixed); end
        end
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (dut.env_state[i] !== ENV_IDLE) begin
                errors++; $display("FAIL idle_state v%0d: got %0d expected %0d", i, dut.env_state[i], ENV_IDLE);
            end
        end
    endtask

    task automatic test_note_on();
        int sus_frames = 0;
        int peak = 0;
        goto_slot(2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 6, TUNE1);
        for (int f = 0; f < 80 && sus_frames < 6; f++) begin
            run_frame();
            checks++;
            if (int'(mixed) !== m_out) begin errors++; $display("FAIL on_out f%0d: got %0d expected %0d", f, mixed, m_out); end
            checks++;
            if (int'(dut.env_level[6]) !== m_lv[6]) begin
                errors++; $display("FAIL on_level f%0d: got %0d expected %0d", f, dut.env_level[6], m_lv[6]);
            end
            checks++;
            if (dut.env_state[6] !== to_env(m_st[6])) begin
                errors++; $display("FAIL on_state f%0d: got %0d expected %0d", f, dut.env_state[6], to_env(m_st[6]));
            end
            if (int'(mixed) > peak) peak = int'(mixed);
            if (m_st[6] == M_SUS) sus_frames++;
        end
        checks++;
        if (dut.env_level[6] !== SUS) begin errors++; $display("FAIL on_sustain_level: got %h expected %h", dut.env_level[6], SUS); end
        checks++;
        if (peak < 16000) begin errors++; $display("FAIL on_peak: got %0d expected >= 16000", peak); end
    endtask

    task automatic test_note_off();
        int idle_frames = 0;
        goto_slot(4);
        step(1'b0, 1'b0, 1'b1, 1'b0, 6, 0);
        for (int f = 0; f < 80 && idle_frames < 3; f++) begin
            run_frame();
            checks++;
            if (int'(mixed) !== m_out) begin errors++; $display("FAIL off_out f%0d: got %0d expected %0d", f, mixed, m_out); end
            checks++;
            if (int'(dut.env_level[6]) !== m_lv[6]) begin
                errors++; $display("FAIL off_level f%0d: got %0d expected %0d", f, dut.env_level[6], m_lv[6]);
            end
            if (m_st[6] == M_IDLE) idle_frames++;
        end
        checks++;
        if (mixed !== 24'sd0) begin errors++; $display("FAIL off_silent: got %0d expected 0", mixed); end
        checks++;
        if (dut.env_state[6] !== ENV_IDLE) begin errors++; $display("FAIL off_state: got %0d expected %0d", dut.env_state[6], ENV_IDLE); end
    endtask

    task automatic test_collision();
        goto_slot(5);
        step(1'b0, 1'b1, 1'b1, 1'b1, 5, 32'h1234_5678);
        checks++;
        if (dut.tuning[5] !== 32'h1234_5678) begin errors++; $display("FAIL coll_tuning: got %h expected 12345678", dut.tuning[5]); end
        checks++;
        if (dut.env_state[5] !== ENV_ATTACK) begin errors++; $display("FAIL coll_state: got %0d expected %0d", dut.env_state[5], ENV_ATTACK); end
        for (int f = 0; f < 4; f++) begin
            run_frame();
            checks++;
            if (int'(mixed) !== m_out) begin errors++; $display("FAIL coll_out f%0d: got %0d expected %0d", f, mixed, m_out); end
        end
    endtask

    task automatic test_out_of_range();
        goto_slot(1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 200, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8, 32'hCAFE_F00D);
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (dut.tuning[i] !== m_tun[i]) begin errors++; $display("FAIL oor_tuning v%0d: got %h expected %h", i, dut.tuning[i], m_tun[i]); end
            checks++;
            if (dut.env_state[i] !== to_env(m_st[i])) begin
                errors++; $display("FAIL oor_state v%0d: got %0d expected %0d", i, dut.env_state[i], to_env(m_st[i]));
            end
        end
    endtask

    task automatic test_two_voices();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 6, TUNE2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 7, TUNE2);
        for (int f = 0; f < 30; f++) begin
            run_frame();
            checks++;
            if (int'(mixed) !== m_out) begin errors++; $display("FAIL two_out f%0d: got %0d expected %0d", f, mixed, m_out); end
            checks++;
            if (int'(mixed) !== 2 * m_contrib[6]) begin
                errors++; $display("FAIL two_double f%0d: got %0d expected %0d", f, mixed, 2 * m_contrib[6]);
            end
        end
    endtask

    task automatic test_random();
        bit fd, fa, ns;
        int idx;
        for (int c = 0; c < NV * 40; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                fd  = 1'($urandom_range(0, 1));
                fa  = 1'($urandom_range(0, 1));
                ns  = ($urandom_range(0, 2) != 0);
                idx = int'($urandom_range(0, 11));
                step(1'b0, fd, fa, ns, idx, $urandom);
            end else begin
                step_idle();
            end
            if (m_slot == 0) begin
                checks++;
                if (int'(mixed) !== m_out) begin errors++; $display("FAIL rnd_out c%0d: got %0d expected %0d", c, mixed, m_out); end
                for (int i = 0; i < NV; i++) begin
                    checks++;
                    if (int'(dut.env_level[i]) !== m_lv[i] || dut.env_state[i] !== to_env(m_st[i]) || dut.tuning[i] !== m_tun[i]) begin
                        errors++;
                        $display("FAIL rnd_voice c%0d v%0d: got lv=%0d st=%0d tun=%h expected lv=%0d st=%0d tun=%h",
                                 c, i, dut.env_level[i], dut.env_state[i], dut.tuning[i], m_lv[i], to_env(m_st[i]), m_tun[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 3, TUNE1);
        run_frame();
        run_frame();
        goto_slot(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (mixed !== 24'sd0) begin errors++; $display("FAIL mrst_out: got %0d expected 0", mixed); end
        checks++;
        if (dut.voice_cnt !== '0) begin errors++; $display("FAIL mrst_cnt: got %0d expected 0", dut.voice_cnt); end
        for (int i = 0; i < NV; i++) begin
            checks++;
            if (dut.env_level[i] !== 16'd0 || dut.env_state[i] !== ENV_IDLE || dut.tuning[i] !== 32'd0 || dut.phase[i] !== 32'd0) begin
                errors++;
                $display("FAIL mrst_voice v%0d: got lv=%0d st=%0d tun=%h ph=%h expected all zero/idle",
                         i, dut.env_level[i], dut.env_state[i], dut.tuning[i], dut.phase[i]);
            end
        end
        for (int f = 0; f < 2; f++) begin
            run_frame();
            checks++;
            if (mixed !== 24'sd0) begin errors++; $display("FAIL mrst_after f%0d: got %0d expected 0", f, mixed); end
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_note_off();
        test_collision();
        test_out_of_range();
        test_two_voices();
        test_random();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/synth_voice_controller.md
Name: synth_voice_controller

Overview:
- Polyphonic synthesizer voice engine sitting between the SPI command decoder and the audio DAC path.
- Holds per-voice DDS oscillator state (tuning word, phase) and ADSR envelope state for NUM_VOICES voices.
- Time-multiplexes one voice per clock and sums all voices into a signed 24-bit mixed sample once per frame.
- The downstream DAC stage takes o_mixed_sample[18:3] plus a DC offset.

Parameters:
- NUM_VOICES, 256: voice count; frame length in clocks; must be a power of two.
- ATTACK_STEP, 16'd64: envelope increment per frame in ATTACK.
- DECAY_STEP, 16'd16: envelope decrement per frame in DECAY.
- SUSTAIN_LEVEL, 16'hC000: envelope hold level.
- RELEASE_STEP, 16'd8: envelope decrement per frame in RELEASE.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_SPI_note_status  in  1  1 = note-on, 0 = note-off; qualified by i_SPI_flag_adsr.
- i_SPI_voice_index  in  8  target voice of the SPI command.
- i_SPI_tuning_code  in  32  DDS phase increment; qualified by i_SPI_flag_dds.
- i_SPI_velocity  in  7  reserved; ignored in this revision and may be left unconnected.
- i_SPI_flag_dds  in  1  one-cycle strobe: write tuning_code to tuning[voice_index].
- i_SPI_flag_adsr  in  1  one-cycle strobe: apply note_status to env[voice_index].
- o_mixed_sample  out  24 signed  mix of all voices; updated once per frame.

Behaviour:
- Reset (sync, high) clears the following, all in one cycle (state held in flop arrays):
  - all tuning, phase and env_level entries to 0; all env_state entries to IDLE;
  - voice counter and accumulator to 0; o_mixed_sample to 0.
- Voice counter v runs 0..NUM_VOICES-1 and wraps. One frame is NUM_VOICES clocks.
- Slot processing for voice v, every clock:
  - phase[v] <= phase[v] + tuning[v], mod 2^32.
  - Saw waveform: saw = signed({~phase[31], phase[30:16]}), a 16-bit signed ramp.
  - Envelope: prod = saw * signed({1'b0, env_level[v]}); contrib = prod[31:16], signed 16 bits.
  - acc <= acc + sign-extended contrib. When v is the first slot of the frame, acc restarts from that contribution.
- Frame output:
  - When v = NUM_VOICES-1, o_mixed_sample <= acc + contrib on that same edge, i.e. the full frame sum.
  - Output latency is 1 clock after the last slot. No saturation is needed: 256 × 16-bit values fit in 24 bits.
- Envelope FSM, per voice, advanced in the voice's own slot (once per frame):
  - IDLE: level holds at 0.
  - ATTACK: level += ATTACK_STEP, saturating at 0xFFFF; on reaching 0xFFFF go to DECAY.
  - DECAY: level -= DECAY_STEP, clamped at SUSTAIN_LEVEL; on reaching it go to SUSTAIN.
  - SUSTAIN: level holds.
  - RELEASE: level -= RELEASE_STEP, floored at 0; on reaching 0 go to IDLE.
- SPI commands take effect on the strobe edge:
  - flag_adsr with note_status=1: state <= ATTACK from the current level (no click reset to 0).
  - flag_adsr with note_status=0: state <= RELEASE. A voice already in IDLE stays IDLE.
  - flag_dds: tuning[idx] <= code. The phase is not reset.
  - Both flags in the same cycle: both updates apply.
- Collision: if an SPI strobe targets the voice in the current slot, the SPI write wins for the field it writes (tuning or env_state). The slot's phase and level updates still commit.
- Voice indices >= NUM_VOICES are ignored.
- Flags held high for several cycles re-apply each cycle; this is harmless.

Decomposition:
- Shared package: env state enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE), default step/level constants, sample width constant (24).
- One natural sub-module: adsr_step, a combinational next-state/next-level function for one voice. It is instantiated once, on the time-shared slot.

Test Plan:
- Reset, no notes: o_mixed_sample = 0 for 10 frames; all envelopes IDLE.
- Note-on, voice 253, tuning 20,000,000 (both flags pulsed 1 cycle):
  - env_level[253] rises by 64 per frame;
  - DECAY at 0xFFFF, then SUSTAIN at 0xC000;
  - o_mixed_sample forms a sawtooth with period ≈ 2^32/20e6 ≈ 214.7 frames and peak magnitude ≈ 0xC000·32767/65536.
- Note-off, voice 253 after sustain: level falls by 8 per frame to 0; state IDLE; output returns to 0 exactly.
- Two voices (252, 253) with equal tuning, note-on on the same frame: output equals 2× the single-voice output, with no overflow.
- Collision: SPI strobe on the slot currently processing voice 5 → tuning[5] equals the new code afterwards.
- Mid-frame reset: all state and o_mixed_sample = 0 on the next edge; voice counter restarts at 0.
